// File: rtl/ft245_sync_responder.sv
`default_nettype none
// ============================================================================
//  Module   : ft245_sync_responder
//  Purpose  : Device-side responder for an FT245-style synchronous FIFO bus.
//             The TOH buffer carries local bytes toward the host and the FRH
//             buffer carries host-written bytes to the local sink. The host
//             sees level flags rxf_n_o and txe_n_o, and any strobe misuse is
//             recorded in sticky error bits.
//  Options  : FT245_RESP_STALL_EN - when defined, a free-running LFSR forces
//             both flags high on pseudo-random cycles to exercise host
//             flow control.
//  Revision : 1.0 - initial release
// ============================================================================
module ft245_sync_responder #(
   parameter int DEPTH_W   = 9,
   parameter int TXE_SLACK = 0
) (
   input  logic       usb_clk_i,
   input  logic       reset_i,
   inout  wire  [7:0] usb_data_io,
   output logic       rxf_n_o,
   output logic       txe_n_o,
   input  logic       rd_n_i,
   input  logic       wr_n_i,
   input  logic       oe_n_i,
   input  logic [7:0] src_data_i,
   input  logic       src_valid_i,
   output logic       src_ready_o,
   output logic [7:0] snk_data_o,
   output logic       snk_valid_o,
   input  logic       snk_ready_i,
   output logic [2:0] err_o,
   input  logic       clr_err_i,
   output logic [1:0] bus_state_o
);

   localparam int               c_DEPTH_N  = 2 ** DEPTH_W;
   localparam logic [DEPTH_W:0] c_DEPTH    = {1'b1, {DEPTH_W{1'b0}}};
   localparam logic [DEPTH_W:0] c_SLACK    = TXE_SLACK[DEPTH_W:0];
   localparam logic [DEPTH_W:0] c_CNT_ONE  = {{DEPTH_W{1'b0}}, 1'b1};
   localparam logic [DEPTH_W-1:0] c_PTR_ONE = {{(DEPTH_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RD_ARM   = 2'd1,
      ST_RD_BURST = 2'd2,
      ST_WR_BURST = 2'd3
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   // Buffer storage and bookkeeping
   logic [7:0]         r_toh_mem [c_DEPTH_N];
   logic [7:0]         r_frh_mem [c_DEPTH_N];
   logic [DEPTH_W-1:0] r_toh_wr_ptr, r_toh_rd_ptr;
   logic [DEPTH_W-1:0] r_frh_wr_ptr, r_frh_rd_ptr;
   logic [DEPTH_W:0]   r_toh_cnt, w_toh_cnt_nxt;
   logic [DEPTH_W:0]   r_frh_cnt, w_frh_cnt_nxt;
   logic [DEPTH_W:0]   w_frh_free_nxt;

   logic       r_rxf_n, r_txe_n;
   logic [2:0] r_err;
   logic       w_stall_nxt;

   logic w_toh_full, w_frh_full;
   logic w_toh_push, w_toh_pop, w_frh_push, w_frh_pop;
   logic w_armed, w_underrun, w_overrun, w_contention;

   // Local-side handshakes
   assign w_toh_full  = (r_toh_cnt == c_DEPTH);
   assign w_frh_full  = (r_frh_cnt == c_DEPTH);
   assign src_ready_o = ~w_toh_full;
   assign w_toh_push  = src_valid_i & ~w_toh_full;
   assign snk_valid_o = (r_frh_cnt != '0);
   assign snk_data_o  = r_frh_mem[r_frh_rd_ptr];
   assign w_frh_pop   = snk_valid_o & snk_ready_i;

   // Host-side strobe decoding. A read only pops when OE was already low on
   // the previous edge (state armed); any other read strobe is an underrun.
   assign w_armed      = (r_state == ST_RD_ARM) || (r_state == ST_RD_BURST);
   assign w_toh_pop    = ~rd_n_i & ~oe_n_i & w_armed & ~r_rxf_n;
   assign w_underrun   = ~rd_n_i & ~w_toh_pop;
   assign w_contention = ~wr_n_i & ~oe_n_i;
   assign w_frh_push   = ~wr_n_i & oe_n_i & ~r_txe_n & ~w_frh_full;
   assign w_overrun    = ~wr_n_i & oe_n_i & r_txe_n;

   // The bus is released during reset so a host holding OE low cannot see
   // stale buffer contents.
   assign usb_data_io = (~oe_n_i & ~reset_i) ? r_toh_mem[r_toh_rd_ptr] : 8'bz;

   assign rxf_n_o     = r_rxf_n;
   assign txe_n_o     = r_txe_n;
   assign err_o       = r_err;
   assign bus_state_o = r_state;

`ifdef FT245_RESP_STALL_EN
   logic [15:0] r_lfsr;
   logic [15:0] w_lfsr_nxt;

   // Fibonacci LFSR, taps 16,14,13,11
   always_comb begin
      w_lfsr_nxt = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
   end

   // Stall generator steps every cycle
   always_ff @(posedge usb_clk_i or posedge reset_i) begin
      if (reset_i) r_lfsr <= 16'hACE1;
      else         r_lfsr <= w_lfsr_nxt;
   end

   // The flags are registered, so the stall is judged on the value the LFSR
   // will hold during the cycle the flags apply to.
   assign w_stall_nxt = (w_lfsr_nxt[1:0] == 2'b11);
`else
   assign w_stall_nxt = 1'b0;
`endif

   // Post-update occupancy of both buffers
   always_comb begin
      w_toh_cnt_nxt = r_toh_cnt;
      if (w_toh_push && !w_toh_pop)      w_toh_cnt_nxt = r_toh_cnt + c_CNT_ONE;
      else if (!w_toh_push && w_toh_pop) w_toh_cnt_nxt = r_toh_cnt - c_CNT_ONE;
      w_frh_cnt_nxt = r_frh_cnt;
      if (w_frh_push && !w_frh_pop)      w_frh_cnt_nxt = r_frh_cnt + c_CNT_ONE;
      else if (!w_frh_push && w_frh_pop) w_frh_cnt_nxt = r_frh_cnt - c_CNT_ONE;
      w_frh_free_nxt = c_DEPTH - w_frh_cnt_nxt;
   end

   // Buffer storage writes (no reset needed on the data array)
   always_ff @(posedge usb_clk_i) begin
      if (w_toh_push) r_toh_mem[r_toh_wr_ptr] <= src_data_i;
      if (w_frh_push) r_frh_mem[r_frh_wr_ptr] <= usb_data_io;
   end

   // Pointers and occupancy; reset empties both buffers
   always_ff @(posedge usb_clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_toh_wr_ptr <= '0;
         r_toh_rd_ptr <= '0;
         r_frh_wr_ptr <= '0;
         r_frh_rd_ptr <= '0;
         r_toh_cnt    <= '0;
         r_frh_cnt    <= '0;
      end else begin
         if (w_toh_push) r_toh_wr_ptr <= r_toh_wr_ptr + c_PTR_ONE;
         if (w_toh_pop)  r_toh_rd_ptr <= r_toh_rd_ptr + c_PTR_ONE;
         if (w_frh_push) r_frh_wr_ptr <= r_frh_wr_ptr + c_PTR_ONE;
         if (w_frh_pop)  r_frh_rd_ptr <= r_frh_rd_ptr + c_PTR_ONE;
         r_toh_cnt <= w_toh_cnt_nxt;
         r_frh_cnt <= w_frh_cnt_nxt;
      end
   end

   // Host-visible flags from post-update occupancy
   always_ff @(posedge usb_clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_rxf_n <= 1'b1;
         r_txe_n <= 1'b1;
      end else begin
         r_rxf_n <= (w_toh_cnt_nxt == '0) | w_stall_nxt;
         r_txe_n <= (w_frh_free_nxt <= c_SLACK) | w_stall_nxt;
      end
   end

   // Sticky errors; a new event wins over a clear in the same cycle
   always_ff @(posedge usb_clk_i or posedge reset_i) begin
      if (reset_i) r_err <= 3'b000;
      else         r_err <= (clr_err_i ? 3'b000 : r_err) | {w_contention, w_underrun, w_overrun};
   end

   // Bus FSM state register
   always_ff @(posedge usb_clk_i or posedge reset_i) begin
      if (reset_i) r_state <= ST_IDLE;
      else         r_state <= w_state_nxt;
   end

   // Bus FSM next state from the sampled strobes
   always_comb begin
      w_state_nxt = ST_IDLE;
      if (!oe_n_i) begin
         if (rd_n_i)       w_state_nxt = ST_RD_ARM;
         else if (w_armed) w_state_nxt = ST_RD_BURST;
         else              w_state_nxt = ST_IDLE;
      end else if (!wr_n_i) begin
         w_state_nxt = ST_WR_BURST;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ft245_sync_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ft245_sync_responder
//  Purpose  : Self-checking bench for ft245_sync_responder: directed
//             scenarios plus a randomized loopback against a queue model.
//             Build with FT245_RESP_STALL_EN to also exercise forced stalls.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ft245_sync_responder;

`ifdef FT245_RESP_STALL_EN
   localparam int LB_N = 1000;
`else
   localparam int LB_N = 300;
`endif
   localparam int DEPTH = 512;

   logic       usb_clk_i = 1'b0;
   logic       reset_i   = 1'b1;
   logic       rd_n = 1'b1, wr_n = 1'b1, oe_n = 1'b1;
   logic       src_valid = 1'b0, snk_ready = 1'b0, clr_err = 1'b0;
   logic [7:0] src_data = 8'h00, host_d = 8'h00;
   logic       host_drv = 1'b0;
   wire  [7:0] usb_data;
   logic       rxf_n, txe_n, src_ready, snk_valid;
   logic [7:0] snk_data;
   logic [2:0] err;
   logic [1:0] bus_state;

   int n_pass = 0, n_total = 0;
   int src_acc = 0, host_pops = 0;
   logic [7:0] rd_q[$];

   assign usb_data = host_drv ? host_d : 8'bz;

   always #5 usb_clk_i = ~usb_clk_i;

   ft245_sync_responder #(.DEPTH_W(9), .TXE_SLACK(0)) dut (
      .usb_clk_i(usb_clk_i), .reset_i(reset_i), .usb_data_io(usb_data),
      .rxf_n_o(rxf_n), .txe_n_o(txe_n), .rd_n_i(rd_n), .wr_n_i(wr_n), .oe_n_i(oe_n),
      .src_data_i(src_data), .src_valid_i(src_valid), .src_ready_o(src_ready),
      .snk_data_o(snk_data), .snk_valid_o(snk_valid), .snk_ready_i(snk_ready),
      .err_o(err), .clr_err_i(clr_err), .bus_state_o(bus_state)
   );

   // Compliant host read: OE low for one edge, then RD low only while rxf_n is low.
   task automatic host_read(input int n, input int max_cyc, output bit ok);
      int got = 0;
      int cyc = 0;
      host_drv = 1'b0; oe_n = 1'b0; rd_n = 1'b1;
      @(negedge usb_clk_i);
      while (got < n && cyc < max_cyc) begin
         if (rxf_n === 1'b0) begin
            rd_n = 1'b0; rd_q.push_back(usb_data); got++; host_pops++;
         end else begin
            rd_n = 1'b1;
         end
         @(negedge usb_clk_i); cyc++;
      end
      rd_n = 1'b1; oe_n = 1'b1;
      ok = (got == n);
   endtask

   // Compliant host write: wait for txe_n low, then one WR pulse.
   task automatic host_write(input logic [7:0] b, input int max_cyc, output bit ok);
      int cyc = 0;
      while (txe_n !== 1'b0 && cyc < max_cyc) begin
         @(negedge usb_clk_i); cyc++;
      end
      ok = 1'b0;
      if (txe_n === 1'b0) begin
         host_d = b; host_drv = 1'b1; wr_n = 1'b0;
         @(negedge usb_clk_i);
         wr_n = 1'b1; host_drv = 1'b0; ok = 1'b1;
      end
   endtask

   task automatic test_reset();
      reset_i = 1'b1;
      repeat (3) @(negedge usb_clk_i);
      n_total++; if (rxf_n !== 1'b1)     $display("FAIL reset_rxf_n got=%b want=1", rxf_n); else n_pass++;
      n_total++; if (txe_n !== 1'b1)     $display("FAIL reset_txe_n got=%b want=1", txe_n); else n_pass++;
      n_total++; if (snk_valid !== 1'b0) $display("FAIL reset_snk_valid got=%b want=0", snk_valid); else n_pass++;
      n_total++; if (err !== 3'b000)     $display("FAIL reset_err got=%b want=000", err); else n_pass++;
      n_total++; if (bus_state !== 2'd0) $display("FAIL reset_state got=%0d want=0", bus_state); else n_pass++;
      n_total++; if (src_ready !== 1'b1) $display("FAIL reset_src_ready got=%b want=1", src_ready); else n_pass++;
      reset_i = 1'b0;
      @(negedge usb_clk_i);
   endtask

   task automatic test_toh_read();
      logic [7:0] exp [3];
      bit ok;
      exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33;
      for (int i = 0; i < 3; i++) begin
         src_data = exp[i]; src_valid = 1'b1;
         @(negedge usb_clk_i);
      end
      src_valid = 1'b0;
      rd_q.delete();
      host_read(3, 200, ok);
      n_total++; if (ok !== 1'b1) $display("FAIL toh_read_done got=%0d want=3", rd_q.size()); else n_pass++;
      for (int i = 0; i < 3; i++) begin
         n_total++;
         if (rd_q.size() <= i || rd_q[i] !== exp[i]) $display("FAIL toh_read_byte%0d got=%h want=%h", i, (rd_q.size() > i) ? rd_q[i] : 8'hxx, exp[i]);
         else n_pass++;
      end
      n_total++; if (rxf_n !== 1'b1)  $display("FAIL toh_read_rxf_empty got=%b want=1", rxf_n); else n_pass++;
      n_total++; if (err !== 3'b000)  $display("FAIL toh_read_err got=%b want=000", err); else n_pass++;
   endtask

   task automatic test_host_write();
      bit ok1, ok2;
      snk_ready = 1'b0;
      host_write(8'hA5, 200, ok1);
      host_write(8'h5A, 200, ok2);
      n_total++; if ((ok1 & ok2) !== 1'b1) $display("FAIL wr_accept got=%b%b want=11", ok1, ok2); else n_pass++;
      n_total++; if (snk_valid !== 1'b1 || snk_data !== 8'hA5) $display("FAIL wr_first got=%b/%h want=1/a5", snk_valid, snk_data); else n_pass++;
      snk_ready = 1'b1;
      @(negedge usb_clk_i);
      n_total++; if (snk_valid !== 1'b1 || snk_data !== 8'h5A) $display("FAIL wr_second got=%b/%h want=1/5a", snk_valid, snk_data); else n_pass++;
      @(negedge usb_clk_i);
      snk_ready = 1'b0;
      n_total++; if (snk_valid !== 1'b0) $display("FAIL wr_drained got=%b want=0", snk_valid); else n_pass++;
      n_total++; if (err !== 3'b000)     $display("FAIL wr_err got=%b want=000", err); else n_pass++;
   endtask

   task automatic test_overrun();
      logic [7:0] exp_q[$];
      logic [7:0] b;
      bit ok;
      int wr_fail = 0, got = 0, mis = 0;
      snk_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         b = 8'($urandom);
         host_write(b, 200, ok);
         if (!ok) wr_fail++;
         exp_q.push_back(b);
      end
      n_total++; if (wr_fail !== 0)  $display("FAIL ovr_fill_timeouts got=%0d want=0", wr_fail); else n_pass++;
      n_total++; if (txe_n !== 1'b1) $display("FAIL ovr_txe_full got=%b want=1", txe_n); else n_pass++;
      host_d = 8'($urandom); host_drv = 1'b1; wr_n = 1'b0;
      @(negedge usb_clk_i);
      wr_n = 1'b1; host_drv = 1'b0;
      n_total++; if (err !== 3'b001) $display("FAIL ovr_err got=%b want=001", err); else n_pass++;
      snk_ready = 1'b1;
      repeat (DEPTH + 40) begin
         if (snk_valid === 1'b1) begin
            if (exp_q.size() == 0) mis++;
            else if (snk_data !== exp_q.pop_front()) mis++;
            got++;
         end
         @(negedge usb_clk_i);
      end
      snk_ready = 1'b0;
      n_total++; if (got !== DEPTH) $display("FAIL ovr_occupancy got=%0d want=%0d", got, DEPTH); else n_pass++;
      n_total++; if (mis !== 0)     $display("FAIL ovr_data_errors got=%0d want=0", mis); else n_pass++;
      clr_err = 1'b1;
      @(negedge usb_clk_i);
      clr_err = 1'b0;
      n_total++; if (err !== 3'b000) $display("FAIL ovr_clear got=%b want=000", err); else n_pass++;
   endtask

   task automatic test_underrun();
      bit ok;
      int cyc = 0;
      oe_n = 1'b0;
      @(negedge usb_clk_i);
      rd_n = 1'b0;
      @(negedge usb_clk_i);
      rd_n = 1'b1; oe_n = 1'b1;
      n_total++; if (err !== 3'b010) $display("FAIL udr_err got=%b want=010", err); else n_pass++;
      n_total++; if (rxf_n !== 1'b1) $display("FAIL udr_rxf got=%b want=1", rxf_n); else n_pass++;
      clr_err = 1'b1;
      @(negedge usb_clk_i);
      clr_err = 1'b0;
      n_total++; if (err !== 3'b000) $display("FAIL udr_clear got=%b want=000", err); else n_pass++;
      // New event in the same cycle as a clear must survive
      rd_n = 1'b0; clr_err = 1'b1;
      @(negedge usb_clk_i);
      rd_n = 1'b1; clr_err = 1'b0;
      n_total++; if (err !== 3'b010) $display("FAIL udr_clr_priority got=%b want=010", err); else n_pass++;
      clr_err = 1'b1;
      @(negedge usb_clk_i);
      clr_err = 1'b0;
      // RD together with OE (no prior arm) on a non-empty buffer: underrun, no pop
      src_data = 8'h77; src_valid = 1'b1;
      @(negedge usb_clk_i);
      src_valid = 1'b0;
      while (rxf_n !== 1'b0 && cyc < 100) begin @(negedge usb_clk_i); cyc++; end
      oe_n = 1'b0; rd_n = 1'b0;
      @(negedge usb_clk_i);
      oe_n = 1'b1; rd_n = 1'b1;
      n_total++; if (err !== 3'b010) $display("FAIL udr_noarm_err got=%b want=010", err); else n_pass++;
      clr_err = 1'b1;
      @(negedge usb_clk_i);
      clr_err = 1'b0;
      rd_q.delete();
      host_read(1, 200, ok);
      n_total++; if (ok !== 1'b1 || rd_q[0] !== 8'h77) $display("FAIL udr_noarm_kept got=%h want=77", (rd_q.size() > 0) ? rd_q[0] : 8'hxx); else n_pass++;
      n_total++; if (err !== 3'b000) $display("FAIL udr_final_err got=%b want=000", err); else n_pass++;
   endtask

   task automatic test_contention();
      host_drv = 1'b0; oe_n = 1'b0; wr_n = 1'b0;
      @(negedge usb_clk_i);
      wr_n = 1'b1; oe_n = 1'b1;
      n_total++; if (err !== 3'b100)     $display("FAIL cont_err got=%b want=100", err); else n_pass++;
      n_total++; if (snk_valid !== 1'b0) $display("FAIL cont_frh_unchanged got=%b want=0", snk_valid); else n_pass++;
      clr_err = 1'b1;
      @(negedge usb_clk_i);
      clr_err = 1'b0;
      n_total++; if (err !== 3'b000)     $display("FAIL cont_clear got=%b want=000", err); else n_pass++;
   endtask

   task automatic test_reset_mid_read();
      for (int i = 0; i < 5; i++) begin
         src_data = 8'(8'h40 + i); src_valid = 1'b1;
         @(negedge usb_clk_i);
      end
      src_valid = 1'b0;
      oe_n = 1'b0;
      @(negedge usb_clk_i);
      rd_n = 1'b0;
      @(negedge usb_clk_i);
      #2 reset_i = 1'b1;
      #1;
      n_total++; if (rxf_n !== 1'b1)     $display("FAIL rst_mid_rxf got=%b want=1", rxf_n); else n_pass++;
      n_total++; if (txe_n !== 1'b1)     $display("FAIL rst_mid_txe got=%b want=1", txe_n); else n_pass++;
      n_total++; if (snk_valid !== 1'b0) $display("FAIL rst_mid_snk_valid got=%b want=0", snk_valid); else n_pass++;
      n_total++; if (err !== 3'b000)     $display("FAIL rst_mid_err got=%b want=000", err); else n_pass++;
      n_total++; if (bus_state !== 2'd0) $display("FAIL rst_mid_state got=%0d want=0", bus_state); else n_pass++;
      n_total++; if (src_ready !== 1'b1) $display("FAIL rst_mid_src_ready got=%b want=1", src_ready); else n_pass++;
      @(negedge usb_clk_i);
      rd_n = 1'b1; oe_n = 1'b1;
      @(negedge usb_clk_i);
      reset_i = 1'b0;
      repeat (3) @(negedge usb_clk_i);
      n_total++; if (rxf_n !== 1'b1) $display("FAIL rst_mid_toh_flushed got=%b want=1", rxf_n); else n_pass++;
      n_total++; if (err !== 3'b000) $display("FAIL rst_mid_no_err got=%b want=000", err); else n_pass++;
   endtask

   task automatic test_loopback();
      logic [7:0] src_bytes[$];
      int snk_cnt = 0, snk_mis = 0, host_mis = 0, host_wr = 0;
      int flag_mis = 0, stall_seen = 0, tmo = 0;
      bit lb_fin = 1'b0;
      for (int i = 0; i < LB_N; i++) src_bytes.push_back(8'($urandom));
      src_acc = 0; host_pops = 0; rd_q.delete();
      fork
         begin : p_src
            int idx = 0;
            int cyc = 0;
            while (idx < LB_N && cyc < 30000) begin
               src_valid = ($urandom_range(0, 3) != 0);
               src_data  = src_bytes[idx];
               if (src_valid && src_ready) begin idx++; src_acc++; end
               @(negedge usb_clk_i); cyc++;
            end
            src_valid = 1'b0;
         end
         begin : p_snk
            int cyc = 0;
            while (snk_cnt < LB_N && cyc < 30000) begin
               snk_ready = ($urandom_range(0, 3) != 0);
               if (snk_ready && snk_valid) begin
                  if (snk_data !== src_bytes[snk_cnt]) snk_mis++;
                  snk_cnt++;
               end
               @(negedge usb_clk_i); cyc++;
            end
            snk_ready = 1'b0;
            lb_fin = 1'b1;
         end
         begin : p_host
            int rd_cnt = 0;
            int k;
            bit ok;
            while (host_wr < LB_N && tmo == 0) begin
               k = (LB_N - rd_cnt > 8) ? int'($urandom_range(1, 8)) : (LB_N - rd_cnt);
               rd_q.delete();
               host_read(k, 4000, ok);
               if (!ok) tmo++;
               else begin
                  for (int j = 0; j < k; j++) if (rd_q[j] !== src_bytes[rd_cnt + j]) host_mis++;
                  rd_cnt += k;
                  for (int j = 0; j < k; j++) begin
                     host_write(rd_q[j], 4000, ok);
                     if (!ok) tmo++;
                     else host_wr++;
                  end
               end
            end
         end
         begin : p_mon
            int occ;
            while (!lb_fin) begin
               @(posedge usb_clk_i);
               #1;
               occ = src_acc - host_pops;
`ifdef FT245_RESP_STALL_EN
               if (occ == 0 && rxf_n !== 1'b1) flag_mis++;
               if (occ != 0 && rxf_n === 1'b1) stall_seen++;
`else
               if (rxf_n !== (occ == 0)) flag_mis++;
`endif
            end
         end
      join
      n_total++; if (tmo !== 0)        $display("FAIL lb_timeouts got=%0d want=0", tmo); else n_pass++;
      n_total++; if (snk_cnt !== LB_N) $display("FAIL lb_count got=%0d want=%0d", snk_cnt, LB_N); else n_pass++;
      n_total++; if (snk_mis !== 0)    $display("FAIL lb_snk_data got=%0d errors want=0", snk_mis); else n_pass++;
      n_total++; if (host_mis !== 0)   $display("FAIL lb_host_data got=%0d errors want=0", host_mis); else n_pass++;
      n_total++; if (flag_mis !== 0)   $display("FAIL lb_rxf_vs_occupancy got=%0d errors want=0", flag_mis); else n_pass++;
      n_total++; if (err !== 3'b000)   $display("FAIL lb_err got=%b want=000", err); else n_pass++;
`ifdef FT245_RESP_STALL_EN
      n_total++; if (stall_seen == 0)  $display("FAIL lb_stall_seen got=%0d want>0", stall_seen); else n_pass++;
`endif
   endtask

   initial begin
      test_reset();
      test_toh_read();
      test_host_write();
      test_overrun();
      test_underrun();
      test_contention();
      test_reset_mid_read();
      test_loopback();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog got=timeout want=finish (%0d/%0d passed)", n_pass, n_total);
      $fatal(1);
   end

endmodule
`default_nettype wire
